majority_voter_nch: RTL and testbench
=====================================

# majority_voter_nch

Parametrised, registered N-channel bitwise majority voter with per-channel disagreement tracking and sticky fault flags. It is the next generation of the team's 3-input majority gate. It sits behind replicated (TMR/NMR) datapaths and delivers one voted word per valid sample, plus diagnostics identifying which replica is misbehaving.

## Interface
Parameters:
- NCH, 3: number of redundant channels; odd, 3..15.
- W, 8: word width per channel.
- FAULT_THRESH, 4: consecutive mismatching samples that latch a channel fault; 1..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: din holds a sample this cycle.
- din, input, NCH*W: channel i occupies bits [i*W +: W].
- clr_fault, input, 1: clears all fault flags and counters.
- dout, output, W: voted word.
- out_valid, output, 1: dout, mismatch and agree_all are valid this cycle.
- mismatch, output, NCH: bit i set when channel i differs from dout in any bit.
- agree_all, output, 1: all voting channels were identical.
- fault, output, NCH: sticky per-channel fault flag.
- all_fault, output, 1: every channel is faulted. Driven only when masking is compiled in; otherwise tied to 0.

## Operation
- Vote per bit b: dout[b] = 1 iff (number of voting channels with bit b = 1) × 2 > (number of voting channels). Ties resolve to 0.
- Without masking, all NCH channels vote and ties cannot occur.
- On an in_valid cycle, the output registers load dout, mismatch, agree_all and out_valid = 1.
- On a non-valid cycle:
  - dout holds.
  - out_valid = 0, mismatch = 0, agree_all = 0.
- Per-channel counter cnt[i], width clog2(FAULT_THRESH+1), updated only on in_valid cycles:
  - Channel mismatches: cnt[i] increments, saturating at FAULT_THRESH.
  - Channel matches: cnt[i] clears to 0.
- fault[i] sets when cnt[i] reaches FAULT_THRESH. It stays set until clr_fault or rst.
- Faulted channels still report mismatch and keep counting (saturated).
- clr_fault: clears fault[] and cnt[] at the next edge.
- clr_fault together with in_valid:
  - The sample is still voted and output.
  - The sample is not counted; counters go to 0 and clear wins.
- Reset values: dout 0, out_valid 0, mismatch 0, agree_all 0, fault 0, all_fault 0, all cnt 0.
- Reset mid-stream discards the in-flight sample; no out_valid follows it.

## Timing
- Latency: 1 cycle. A sample with in_valid at edge t appears with out_valid = 1 after edge t+1.
- Throughput: one sample per cycle. No backpressure; the consumer must accept every out_valid.
- fault[i] asserts in the same cycle out_valid presents the FAULT_THRESH-th consecutive mismatch of channel i.
- Masking (when enabled) uses fault[] as registered before the current edge. A channel that faults on sample k is first excluded on sample k+1.
- rst has priority over clr_fault and in_valid.

## Configuration
- Macro MAJ_FAULT_MASK_EN.
- Defined:
  - Channels with fault[i] = 1 are excluded from the vote.
  - The vote denominator is the number of unfaulted channels.
  - agree_all considers only unfaulted channels.
  - If all channels are faulted: all_fault = 1, dout holds its previous value, out_valid still pulses, mismatch is computed against the held dout.
- Undefined:
  - All channels always vote.
  - fault[] is diagnostic only.
  - all_fault is constant 0.

## Test plan
All scenarios use NCH=3, W=8, FAULT_THRESH=4.
1. Reset: assert rst 2 cycles while in_valid = 1 and din = {8'hFF, 8'hFF, 8'hFF}. Required: out_valid = 0 and dout = 8'h00 during reset and the cycle after.
2. Bitwise vote: din = {8'hF0, 8'hCC, 8'hAA} with in_valid. Required, next cycle: dout = 8'hE8, mismatch = 3'b111, agree_all = 0, out_valid = 1.
3. Fault latch: channel 1 = 8'h00, channels 0 and 2 = 8'h5A, for 4 consecutive valid samples. Required: mismatch = 3'b010 each output; fault = 3'b010 exactly with the 4th out_valid. A match on sample 3 instead restarts the count and no fault is raised.
4. Clear collision: after fault = 3'b010, assert clr_fault together with a mismatching sample. Required: fault = 3'b000; a further 4 mismatches are needed to re-fault.
5. Masking (MAJ_FAULT_MASK_EN): channel 0 faulted, then din = {8'h0F, 8'hF0, 8'hFF}. Required: tie resolves dout = 8'h00. Fault channels 1 and 2 as well. Required: all_fault = 1 and dout holds.
6. Gaps: in_valid toggled 1,0,1 with identical inputs 8'h3C. Required: out_valid = 1,0,1; dout = 8'h3C held throughout; counters unchanged on idle cycles.

Source files
------------

// File: rtl/majority_voter_nch.sv
// Registered N-channel bitwise majority voter with per-channel mismatch counters and sticky fault flags.
// Build option: define MAJ_FAULT_MASK_EN to drop faulted channels from the vote and drive all_fault.
module majority_voter_nch #(
    parameter int NCH          = 3,
    parameter int W            = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [NCH*W-1:0]   din,
    input  logic               clr_fault,
    output logic [W-1:0]       dout,
    output logic               out_valid,
    output logic [NCH-1:0]     mismatch,
    output logic               agree_all,
    output logic [NCH-1:0]     fault,
    output logic               all_fault
);
    localparam int CW = $clog2(FAULT_THRESH + 1);
    // One spare bit so that twice the ones count never overflows against the voter count.
    localparam int VW = $clog2(NCH + 1) + 1;
    localparam logic [CW-1:0] THRESH = CW'(FAULT_THRESH);

    logic [W-1:0]              r_dout;
    logic                      r_outValid;
    logic [NCH-1:0]            r_mismatch;
    logic                      r_agreeAll;
    logic [NCH-1:0]            r_fault;
    logic [NCH-1:0][CW-1:0]    r_cnt;

    logic [NCH-1:0]            w_voteEn;
    logic [VW-1:0]             w_voters;
    logic [VW-1:0]             w_ones;
    logic [W-1:0]              w_vote;
    logic [NCH-1:0]            w_mismatch;
    logic                      w_agreeAll;
    logic [NCH-1:0][CW-1:0]    w_cntNext;
    logic [NCH-1:0]            w_faultNext;

`ifdef MAJ_FAULT_MASK_EN
    assign w_voteEn  = ~r_fault;
    assign all_fault = &r_fault;
`else
    assign w_voteEn  = '1;
    assign all_fault = 1'b0;
`endif

    always_comb begin
        w_voters = '0;
        for (int i = 0; i < NCH; i++) begin
            w_voters = w_voters + {{(VW-1){1'b0}}, w_voteEn[i]};
        end
    end

    // With no voters left the previous word is held, which also makes mismatch compare against it.
    always_comb begin
        w_vote = r_dout;
        w_ones = '0;
        for (int b = 0; b < W; b++) begin
            w_ones = '0;
            for (int i = 0; i < NCH; i++) begin
                if (w_voteEn[i]) begin
                    w_ones = w_ones + {{(VW-1){1'b0}}, din[i*W + b]};
                end
            end
            if (w_voters != '0) begin
                w_vote[b] = (w_ones + w_ones) > w_voters;
            end
        end
    end

    always_comb begin
        w_mismatch = '0;
        for (int i = 0; i < NCH; i++) begin
            w_mismatch[i] = (din[i*W +: W] != w_vote);
        end
        w_agreeAll = (w_voters != '0) && ((w_mismatch & w_voteEn) == '0);
    end

    // A clear always wins over counting, even when it lands on a valid sample.
    always_comb begin
        w_cntNext   = r_cnt;
        w_faultNext = r_fault;
        if (clr_fault) begin
            w_cntNext   = '0;
            w_faultNext = '0;
        end else if (in_valid) begin
            for (int i = 0; i < NCH; i++) begin
                if (!w_mismatch[i]) begin
                    w_cntNext[i] = '0;
                end else if (r_cnt[i] != THRESH) begin
                    w_cntNext[i] = r_cnt[i] + 1'b1;
                end
                if (w_cntNext[i] == THRESH) begin
                    w_faultNext[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_outValid <= 1'b0;
            r_mismatch <= '0;
            r_agreeAll <= 1'b0;
            r_fault    <= '0;
            r_cnt      <= '0;
        end else begin
            r_outValid <= in_valid;
            r_fault    <= w_faultNext;
            r_cnt      <= w_cntNext;
            if (in_valid) begin
                r_dout     <= w_vote;
                r_mismatch <= w_mismatch;
                r_agreeAll <= w_agreeAll;
            end else begin
                r_mismatch <= '0;
                r_agreeAll <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_outValid;
    assign mismatch  = r_mismatch;
    assign agree_all = r_agreeAll;
    assign fault     = r_fault;
endmodule

// File: tb/tb_majority_voter_nch.sv
// Directed self-checking bench for majority_voter_nch with NCH=3, W=8, FAULT_THRESH=4.
// Observed vector per check: {out_valid, dout, mismatch, agree_all, fault, all_fault}.
module tb_majority_voter_nch;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [23:0] din;
    logic        clr_fault;
    logic [7:0]  dout;
    logic        out_valid;
    logic [2:0]  mismatch;
    logic        agree_all;
    logic [2:0]  fault;
    logic        all_fault;

    int          assertCount;
    int          failCount;
    logic [16:0] got;
    logic [16:0] exp;

    majority_voter_nch #(.NCH(3), .W(8), .FAULT_THRESH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr_fault(clr_fault),
        .dout(dout), .out_valid(out_valid), .mismatch(mismatch), .agree_all(agree_all),
        .fault(fault), .all_fault(all_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic applyStimulus(input logic v, input logic [23:0] d, input logic c);
        in_valid  = v;
        din       = d;
        clr_fault = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 24'hFFFFFF, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL reset_hold%0d: got %h expected %h", k, got, exp); end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL reset_release: got %h expected %h", got, exp); end
        applyStimulus(1'b0, 24'hFFFFFF, 1'b0);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL reset_after: got %h expected %h", got, exp); end
    endtask

    task automatic test_vote;
        applyStimulus(1'b1, {8'hF0, 8'hCC, 8'hAA}, 1'b0);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        exp = {1'b1, 8'hE8, 3'b111, 1'b0, 3'b000, 1'b0};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL vote_bitwise: got %h expected %h", got, exp); end
        applyStimulus(1'b0, {8'hF0, 8'hCC, 8'hAA}, 1'b1);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        exp = {1'b0, 8'hE8, 3'b000, 1'b0, 3'b000, 1'b0};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL vote_idle_clear: got %h expected %h", got, exp); end
    endtask

    // Sample index 2 matches and restarts channel 1's run; only the 4th mismatch after it faults.
    task automatic test_fault_restart;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) applyStimulus(1'b1, {8'h5A, 8'h5A, 8'h5A}, 1'b0);
            else        applyStimulus(1'b1, {8'h5A, 8'h00, 8'h5A}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {1'b1, 8'h5A, (k == 2) ? 3'b000 : 3'b010, (k == 2), (k == 6) ? 3'b010 : 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL restart_s%0d: got %h expected %h", k, got, exp); end
        end
    endtask

    task automatic test_clear_collision;
        applyStimulus(1'b1, {8'h5A, 8'h00, 8'h5A}, 1'b1);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        exp = {1'b1, 8'h5A, 3'b010, 1'b0, 3'b000, 1'b0};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL collision: got %h expected %h", got, exp); end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, {8'h5A, 8'h00, 8'h5A}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {1'b1, 8'h5A, 3'b010, 1'b0, (k == 3) ? 3'b010 : 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL refault_s%0d: got %h expected %h", k, got, exp); end
        end
    endtask

    task automatic test_fault_latch;
        applyStimulus(1'b0, 24'h000000, 1'b1);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        exp = {1'b0, 8'h5A, 3'b000, 1'b0, 3'b000, 1'b0};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL latch_clear: got %h expected %h", got, exp); end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, {8'hC3, 8'h3C, 8'hC3}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {1'b1, 8'hC3, 3'b010, 1'b0, (k == 3) ? 3'b010 : 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL latch_s%0d: got %h expected %h", k, got, exp); end
        end
    endtask

    task automatic test_gaps;
        applyStimulus(1'b0, 24'h000000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus((k != 1), {8'h3C, 8'h3C, 8'h3C}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {(k != 1), 8'h3C, 3'b000, (k != 1), 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL gap_s%0d: got %h expected %h", k, got, exp); end
        end
        // Idle cycles between mismatches must neither advance nor reset channel 1's count.
        for (int k = 0; k < 7; k++) begin
            applyStimulus((k % 2 == 0), {8'h3C, 8'hFF, 8'h3C}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {(k % 2 == 0), 8'h3C, (k % 2 == 0) ? 3'b010 : 3'b000, 1'b0, (k == 6) ? 3'b010 : 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL gapcount_s%0d: got %h expected %h", k, got, exp); end
        end
    endtask

`ifdef MAJ_FAULT_MASK_EN
    task automatic test_masking;
        applyStimulus(1'b0, 24'h000000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, {8'hFF, 8'hFF, 8'h00}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {1'b1, 8'hFF, 3'b001, 1'b0, (k == 3) ? 3'b001 : 3'b000, 1'b0};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL mask_fault0_s%0d: got %h expected %h", k, got, exp); end
        end
        applyStimulus(1'b1, {8'h0F, 8'hF0, 8'hFF}, 1'b0);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        exp = {1'b1, 8'h00, 3'b111, 1'b0, 3'b001, 1'b0};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL mask_tie: got %h expected %h", got, exp); end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, {8'h0F, 8'hF3, 8'h00}, 1'b0);
            got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
            exp = {1'b1, 8'h03, 3'b111, 1'b0, (k == 2) ? 3'b111 : 3'b001, (k == 2)};
            assertCount++;
            if (got !== exp) begin failCount++; $display("[TB] FAIL mask_fault12_s%0d: got %h expected %h", k, got, exp); end
        end
        applyStimulus(1'b1, {8'hAA, 8'hBB, 8'h03}, 1'b0);
        got = {out_valid, dout, mismatch, 1'b0, fault, all_fault};
        exp = {1'b1, 8'h03, 3'b110, 1'b0, 3'b111, 1'b1};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL mask_allfault_hold: got %h expected %h", got, exp); end
        applyStimulus(1'b0, 24'h000000, 1'b1);
        got = {out_valid, dout, mismatch, agree_all, fault, all_fault};
        exp = {1'b0, 8'h03, 3'b000, 1'b0, 3'b000, 1'b0};
        assertCount++;
        if (got !== exp) begin failCount++; $display("[TB] FAIL mask_clear: got %h expected %h", got, exp); end
    endtask
`endif

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        din         = '0;
        clr_fault   = 1'b0;
        test_reset();
        test_vote();
        test_fault_restart();
        test_clear_collision();
        test_fault_latch();
        test_gaps();
`ifdef MAJ_FAULT_MASK_EN
        test_masking();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
